// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a 2**AW x DW dual-port RAM into a valid/ready FIFO.
// Define RAMFIFO_FLUSH_EN to add a synchronous flush input.
module ram_fifo_ctrl #(
   parameter int AW = 7,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef RAMFIFO_FLUSH_EN
   input  logic          flush,
`endif
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] ram_wa,
   output logic [DW-1:0] ram_wd,
   output logic          ram_we,
   output logic [AW-1:0] ram_ra,
   input  logic [DW-1:0] ram_q,
   output logic [AW+1:0] level
);

   localparam logic [AW:0] LP_FULL = {1'b1, {AW{1'b0}}};

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_mem_cnt;
   logic          r_inflight;
   logic [1:0]    r_out_occ;
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_skid;

   logic          w_flush;
   logic          w_push;
   logic          w_pop;
   logic          w_fetch;
   logic [1:0]    w_occ_nxt;
   logic [2:0]    w_pend;

`ifdef RAMFIFO_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign wr_ready  = (r_mem_cnt != LP_FULL) & ~w_flush;
   assign w_push    = wr_valid & wr_ready;
   assign rd_valid  = (r_out_occ != 2'd0);
   assign w_pop     = rd_valid & rd_ready;
   assign w_occ_nxt = r_out_occ - {1'b0, w_pop};
   assign w_pend    = {1'b0, w_occ_nxt} + {2'b00, r_inflight};
   // Keep at most two words between the output stage and the RAM pipe
   assign w_fetch   = (r_mem_cnt != '0) & (w_pend < 3'd2) & ~w_flush;

   assign ram_we  = w_push;
   assign ram_wa  = r_wptr;
   assign ram_wd  = wr_data;
   assign ram_ra  = r_rptr;
   assign rd_data = r_head;

   assign level = {1'b0, r_mem_cnt}
                + {{(AW+1){1'b0}}, r_inflight}
                + {{AW{1'b0}}, r_out_occ};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_mem_cnt  <= '0;
         r_inflight <= 1'b0;
         r_out_occ  <= 2'd0;
      end else if (w_flush) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_mem_cnt  <= '0;
         r_inflight <= 1'b0;
         r_out_occ  <= 2'd0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_fetch)
            r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_fetch})
            2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
            2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
            default: r_mem_cnt <= r_mem_cnt;
         endcase
         r_inflight <= w_fetch;
         r_out_occ  <= w_pend[1:0];
      end
   end

   // Head is refilled from skid on pop, else from the returning RAM word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_skid <= '0;
      end else if (!w_flush) begin
         if (w_pop && (r_out_occ == 2'd2))
            r_head <= r_skid;
         else if (r_inflight && (w_occ_nxt == 2'd0))
            r_head <= ram_q;
         if (r_inflight && (w_occ_nxt == 2'd1))
            r_skid <= ram_q;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: random and directed checks of ram_fifo_ctrl against a
// queue-based FIFO model with a behavioural 128x8 RAM attached.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = 8'h00;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic [7:0] rd_data;
   logic [6:0] ram_wa;
   logic [7:0] ram_wd;
   logic       ram_we;
   logic [6:0] ram_ra;
   logic [7:0] ram_q;
   logic [8:0] level;
`ifdef RAMFIFO_FLUSH_EN
   logic       flush = 1'b0;
`endif

   ram_fifo_ctrl #(.AW(7), .DW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef RAMFIFO_FLUSH_EN
      .flush    (flush),
`endif
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .ram_wa   (ram_wa),
      .ram_wd   (ram_wd),
      .ram_we   (ram_we),
      .ram_ra   (ram_ra),
      .ram_q    (ram_q),
      .level    (level)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [128];
   always @(posedge clk) begin
      if (ram_we)
         mem[ram_wa] <= ram_wd;
      ram_q <= mem[ram_ra];
   end

   int ncmp = 0;
   int nerr = 0;
   int cyc  = 0;

   logic [7:0] ramq [$];
   logic [7:0] outq [$];
   bit         m_inf;
   logic [7:0] m_infd;
   logic [7:0] m_head;
   int         m_wcnt;
   bit         m_push;

   logic [7:0] got [$];
   int         pcyc [$];

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      ramq.delete();
      outq.delete();
      m_inf  = 1'b0;
      m_wcnt = 0;
   endtask

   // One clock cycle: drive inputs, compare outputs, advance model
   task automatic cycle(input bit wv, input logic [7:0] wd,
                        input bit rr, input bit fl);
      bit pop;
      bit fetch;
      int occ_after;
      @(negedge clk);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
`ifdef RAMFIFO_FLUSH_EN
      flush    = fl;
`endif
      #1;
      m_push = wv && !fl && (ramq.size() != 128);
      pop    = (outq.size() != 0) && rr && !fl;
      chk("wr_ready", int'(wr_ready), int'(!fl && ramq.size() != 128));
      chk("rd_valid", int'(rd_valid), int'(outq.size() != 0));
      chk("rd_data", int'(rd_data), int'(m_head));
      chk("level", int'(level), ramq.size() + int'(m_inf) + outq.size());
      chk("ram_we", int'(ram_we), int'(m_push));
      if (m_push) begin
         chk("ram_wa", int'(ram_wa), m_wcnt % 128);
         chk("ram_wd", int'(ram_wd), int'(wd));
      end
      if (rd_valid && rr && !fl) begin
         got.push_back(rd_data);
         pcyc.push_back(cyc);
      end
      if (fl) begin
         model_clear();
      end else begin
         occ_after = outq.size() - (pop ? 1 : 0);
         fetch = (ramq.size() > 0) && (occ_after + int'(m_inf) < 2);
         if (pop)
            void'(outq.pop_front());
         if (m_inf)
            outq.push_back(m_infd);
         m_inf = fetch;
         if (fetch)
            m_infd = ramq.pop_front();
         if (m_push) begin
            ramq.push_back(wd);
            m_wcnt++;
         end
         if (outq.size() != 0)
            m_head = outq[0];
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
`ifdef RAMFIFO_FLUSH_EN
      flush    = 1'b0;
`endif
      #1;
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_wr_ready", int'(wr_ready), 1);
      chk("rst_rd_data", int'(rd_data), 0);
      model_clear();
      m_head = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int n, input int budget);
      int g = 0;
      while (got.size() < n && g < budget) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         g++;
      end
      chk("drain_cnt", got.size(), n);
   endtask

   initial begin
      int c0;
      int n;
      int g;
      bit wv;

      // Single word latency
      do_reset();
      got.delete();
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t1_c2_valid", int'(rd_valid), 0);
      @(posedge clk); #1;
      chk("t1_c3_valid", int'(rd_valid), 1);
      chk("t1_c3_data", int'(rd_data), 8'hA5);
      chk("t1_c3_level", int'(level), 1);
      drain(1, 10);

      // Fill to full: 130 words held
      do_reset();
      got.delete();
      for (int i = 0; i < 130; i++)
         cycle(1'b1, 8'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("t2_wr_ready", int'(wr_ready), 0);
      chk("t2_level", int'(level), 130);
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      drain(130, 400);
      for (int i = 0; i < got.size(); i++)
         chk("t2_data", int'(got[i]), i & 255);

      // Streaming with pointer wrap
      do_reset();
      got.delete();
      pcyc.delete();
      c0 = cyc;
      for (int i = 0; i < 300; i++)
         cycle(1'b1, 8'(i), 1'b1, 1'b0);
      drain(300, 50);
      if (got.size() == 300) begin
         chk("t3_first_pop", pcyc[0] - c0, 3);
         chk("t3_rate", pcyc[299] - pcyc[0], 299);
      end
      for (int i = 0; i < got.size(); i++)
         chk("t3_data", int'(got[i]), i & 255);

      // Random traffic and stalls
      do_reset();
      got.delete();
      n = 0;
      g = 0;
      while (got.size() < 1000 && g < 20000) begin
         wv = (n < 1000) && ($urandom_range(0, 9) < 7);
         cycle(wv, 8'(n), 1'($urandom_range(0, 1)), 1'b0);
         if (m_push)
            n++;
         g++;
      end
      chk("t4_count", got.size(), 1000);
      for (int i = 0; i < got.size(); i++)
         chk("t4_data", int'(got[i]), i & 255);

      // Reset with words buffered and a fetch in flight
      do_reset();
      got.delete();
      for (int i = 0; i < 6; i++)
         cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("t5_level_pre", int'(level), 5);
      do_reset();
      got.delete();
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("t5_valid", int'(rd_valid), 1);
      chk("t5_data", int'(rd_data), 8'h5A);
      drain(1, 10);

`ifdef RAMFIFO_FLUSH_EN
      // Flush while holding three words
      do_reset();
      got.delete();
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 8'h77, 1'b0, 1'b1);
      chk("t6_we", int'(ram_we), 0);
      @(posedge clk); #1;
      chk("t6_level", int'(level), 0);
      chk("t6_hold", int'(rd_data), 8'h20);
      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      drain(1, 20);
      if (got.size() == 1)
         chk("t6_data", int'(got[0]), 8'h3C);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
